// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8x16 register file plus a two-cycle read sequencer feeding the shifter.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data into the operand being latched.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift_in,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  // state | meaning
  // IDLE  | waiting for start; rn/rm/shift_in latched on acceptance
  // RD_A  | reading reg[rn_q] into operand A
  // RD_B  | reading reg[rm_q] into operand B
  // DONE  | operands coherent, valid pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rn_q, rn_d;
  logic [ADDR_W-1:0] rm_q, rm_d;
  logic [1:0]        shift_q, shift_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (write) regs_d[writenum] = data_in;
  end

  always_comb begin
    rd_a = regs_q[rn_q];
    rd_b = regs_q[rm_q];
`ifdef REGFILE_BYPASS_EN
    if (write && (writenum == rn_q)) rd_a = data_in;
    if (write && (writenum == rm_q)) rd_b = data_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_A;
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift_in;
        end
      end
      RD_A: begin
        state_d = RD_B;
        a_d     = rd_a;
      end
      RD_B: begin
        state_d = DONE;
        b_d     = rd_b;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      b_q     <= b_d;
      regs_q  <= regs_d;
    end
  end

  assign busy      = (state_q == RD_A) || (state_q == RD_B);
  assign valid     = (state_q == DONE);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table plus scoreboard queue of expected operand sets.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  rn, rm, writenum;
  logic [1:0]  shift_in;
  logic        write;
  logic [15:0] data_in;
  logic        busy, valid;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift_in(shift_in),
    .write(write), .writenum(writenum), .data_in(data_in),
    .busy(busy), .valid(valid), .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sh;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [2:0]  widx;
    logic [15:0] wdata;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [1:0]  esh;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[5];
  logic [15:0] mregs[8];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Advance one clock and score any valid pulse against the queue head.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("a_out", 32'(a_out), 32'(e.a));
        chk("b_out", 32'(b_out), 32'(e.b));
        chk("shift_out", 32'(shift_out), 32'(e.sh));
      end
    end
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [15:0] d);
    write = 1'b1; writenum = idx; data_in = d;
    step();
    write = 1'b0;
    mregs[idx] = d;
  endtask

  task automatic fetch(input logic [2:0] a_idx, input logic [2:0] b_idx, input logic [1:0] sh,
                       input logic [15:0] ea, input logic [15:0] eb);
    int n;
    int busy_cnt;
    start = 1'b1; rn = a_idx; rm = b_idx; shift_in = sh;
    exp_q.push_back('{a: ea, b: eb, sh: sh});
    step();
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!valid && n < 8) begin
      if (busy) busy_cnt++;
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd2);
    chk("busy_cycles", 32'(busy_cnt), 32'd2);
    chk("valid_busy_in_done", 32'(busy), 32'd0);
    step();
    chk("valid_one_cycle", 32'(valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rn = '0; rm = '0; shift_in = '0;
    write = 1'b0; writenum = '0; data_in = '0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;

    vecs[0] = '{wr: 1'b0, widx: 3'd0, wdata: 16'h0000, rn: 3'd0, rm: 3'd7, sh: 2'b11,
                ea: 16'h0000, eb: 16'h0000, esh: 2'b11};
    vecs[1] = '{wr: 1'b1, widx: 3'd5, wdata: 16'h1234, rn: 3'd5, rm: 3'd0, sh: 2'b10,
                ea: 16'h1234, eb: 16'h0000, esh: 2'b10};
    vecs[2] = '{wr: 1'b1, widx: 3'd2, wdata: 16'hF0CF, rn: 3'd5, rm: 3'd2, sh: 2'b01,
                ea: 16'h1234, eb: 16'hF0CF, esh: 2'b01};
    vecs[3] = '{wr: 1'b1, widx: 3'd0, wdata: 16'h8001, rn: 3'd0, rm: 3'd5, sh: 2'b00,
                ea: 16'h8001, eb: 16'h1234, esh: 2'b00};
    vecs[4] = '{wr: 1'b1, widx: 3'd6, wdata: 16'h0F0F, rn: 3'd6, rm: 3'd6, sh: 2'b10,
                ea: 16'h0F0F, eb: 16'h0F0F, esh: 2'b10};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 32'(a_out), 32'd0);
    chk("rst_b", 32'(b_out), 32'd0);
    chk("rst_shift", 32'(shift_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].widx, vecs[i].wdata);
      fetch(vecs[i].rn, vecs[i].rm, vecs[i].sh, vecs[i].ea, vecs[i].eb);
      chk("vec_shift_hold", 32'(shift_out), 32'(vecs[i].esh));
    end

    // Collision: write R3 during RD_A while A latches R3.
    wr_reg(3'd3, 16'hAAAA);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back('{a: 16'h5555, b: 16'h5555, sh: 2'b00});
`else
    exp_q.push_back('{a: 16'hAAAA, b: 16'h5555, sh: 2'b00});
`endif
    start = 1'b1; rn = 3'd3; rm = 3'd3; shift_in = 2'b00;
    step();
    start = 1'b0;
    write = 1'b1; writenum = 3'd3; data_in = 16'h5555;
    step();
    write = 1'b0;
    mregs[3] = 16'h5555;
    step();
    chk("coll_valid", 32'(valid), 32'd1);
    step();

    // Write R7 while the FSM sits in DONE.
    exp_q.push_back('{a: mregs[1], b: mregs[2], sh: 2'b01});
    start = 1'b1; rn = 3'd1; rm = 3'd2; shift_in = 2'b01;
    step();
    start = 1'b0;
    step();
    step();
    chk("done_valid", 32'(valid), 32'd1);
    write = 1'b1; writenum = 3'd7; data_in = 16'hFFFF;
    step();
    write = 1'b0;
    mregs[7] = 16'hFFFF;
    fetch(3'd7, 3'd7, 2'b11, 16'hFFFF, 16'hFFFF);

    // Start held high: one fetch per four cycles, start ignored while busy/valid.
    for (int k = 0; k < 3; k++) exp_q.push_back('{a: mregs[1], b: mregs[2], sh: 2'b10});
    start = 1'b1; rn = 3'd1; rm = 3'd2; shift_in = 2'b10;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("hold_busy", 32'(busy), ((j % 4) == 1 || (j % 4) == 2) ? 32'd1 : 32'd0);
      chk("hold_valid", 32'(valid), ((j % 4) == 3) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    chk("hold_drained", 32'(exp_q.size()), 32'd0);

    // Reset during RD_B: outputs clear at once, fetch is lost, registers clear.
    start = 1'b1; rn = 3'd5; rm = 3'd2; shift_in = 2'b11;
    step();
    start = 1'b0;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_a", 32'(a_out), 32'd0);
    chk("async_b", 32'(b_out), 32'd0);
    chk("async_shift", 32'(shift_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_valid", 32'(valid), 32'd0);
    end
    fetch(3'd5, 3'd2, 2'b01, mregs[5], mregs[2]);
    fetch(3'd7, 3'd3, 2'b10, 16'h0000, 16'h0000);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
